// File: rtl/priority_encoder_4to2.sv
// Purpose: 4-request priority encoder; d3 has the highest priority. The winning index is driven on {a,b} and v is set when any request is active.
// Latency: 1 cycle when OUTPUT_REG=1 (registered outputs); 0 cycles when OUTPUT_REG=0 (purely combinational outputs).
// Backpressure: none. Outputs are re-evaluated every cycle, and consumers must qualify {a,b} with v.
//
// Ports:
//   d0..d3 : request inputs (d0 lowest priority, d3 highest)
//   a, b   : encoded index of the winning request (a = MSB)
//   v      : 1 when any of d0..d3 is set
//   clk    : rising-edge clock (used only when OUTPUT_REG=1)
//   rst    : synchronous active-high reset (used only when OUTPUT_REG=1)
module priority_encoder_4to2 #(
   parameter bit OUTPUT_REG = 1'b1
) (
   input  logic d0,
   input  logic d1,
   input  logic d2,
   input  logic d3,
   output logic a,
   output logic b,
   output logic v,
   input  logic clk,
   input  logic rst
);

   logic enc_a;
   logic enc_b;
   logic enc_v;

   // Closed-form priority equations.
   // b is set for index 1 only when d2 is not masking it.
   always_comb begin
      enc_a = d3 | d2;
      enc_b = d3 | (~d2 & d1);
      enc_v = d3 | d2 | d1 | d0;
   end

   generate
      if (OUTPUT_REG) begin : g_reg
         logic a_q;
         logic b_q;
         logic v_q;

         // Reset has priority over the inputs on the same edge.
         always_ff @(posedge clk) begin
            if (rst) begin
               a_q <= 1'b0;
               b_q <= 1'b0;
               v_q <= 1'b0;
            end else begin
               a_q <= enc_a;
               b_q <= enc_b;
               v_q <= enc_v;
            end
         end

         assign a = a_q;
         assign b = b_q;
         assign v = v_q;
      end else begin : g_comb
         // clk and rst have no function in the combinational build.
         logic unused_clk_rst;
         assign unused_clk_rst = clk ^ rst;

         assign a = enc_a;
         assign b = enc_b;
         assign v = enc_v;
      end
   endgenerate

endmodule

// File: tb/tb_priority_encoder_4to2.sv
// Purpose: scoreboard bench driving one stimulus stream into a registered and a combinational encoder.
// Latency: expected values are tagged with the cycle in which they must appear (same cycle / next cycle).
// Backpressure: none; a negedge monitor pops and compares every due entry.
module tb_priority_encoder_4to2;

   typedef struct {
      int         due;
      logic [2:0] exp;   // {a,b,v}
   } exp_t;

   logic clk;
   logic rst;
   logic [3:0] d;
   logic ra, rb, rv;
   logic ca, cb, cv;

   int cyc;
   int n_cmp;
   int n_bad;
   exp_t q_reg[$];
   exp_t q_comb[$];

   priority_encoder_4to2 #(.OUTPUT_REG(1'b1)) u_reg (
      .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
      .a(ra), .b(rb), .v(rv),
      .clk(clk), .rst(rst)
   );

   priority_encoder_4to2 #(.OUTPUT_REG(1'b0)) u_comb (
      .d0(d[0]), .d1(d[1]), .d2(d[2]), .d3(d[3]),
      .a(ca), .b(cb), .v(cv),
      .clk(clk), .rst(rst)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference: index of the highest set request, plus an any-set flag.
   function automatic logic [2:0] ref_enc(input logic [3:0] dv);
      int idx;
      idx = -1;
      for (int i = 0; i < 4; i++)
         if (dv[i]) idx = i;
      if (idx < 0) return 3'b000;
      return {idx[1:0], 1'b1};
   endfunction

   task automatic check_q(input string name, inout exp_t q[$], input logic [2:0] got);
      while (q.size() > 0 && q[0].due <= cyc) begin
         n_cmp++;
         if (q[0].due < cyc) begin
            n_bad++;
            $display("FAIL %s stale entry due %0d at cycle %0d: got abv=%b required %b",
                     name, q[0].due, cyc, got, q[0].exp);
         end else if (got !== q[0].exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got abv=%b required %b", name, cyc, got, q[0].exp);
         end
         void'(q.pop_front());
      end
   endtask

   // Monitor: outputs are sampled mid-cycle, away from the active edge.
   always @(negedge clk) begin
      check_q("comb", q_comb, {ca, cb, cv});
      check_q("reg", q_reg, {ra, rb, rv});
   end

   task automatic apply(input logic [3:0] dv, input logic r);
      exp_t e;
      logic [2:0] m;
      d   = dv;
      rst = r;
      m   = ref_enc(dv);
      e.due = cyc;
      e.exp = m;
      q_comb.push_back(e);
      e.due = cyc + 1;
      e.exp = r ? 3'b000 : m;
      q_reg.push_back(e);
      @(posedge clk);
      #1;
   endtask

   logic [3:0] dir_vec [0:17];

   initial begin
      n_cmp = 0;
      n_bad = 0;
      d   = 4'b0000;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // The reset edge must override d3=1.
      apply(4'b1000, 1'b1);

      // Directed patterns, packed as {d3,d2,d1,d0}.
      dir_vec[0]  = 4'b0000; dir_vec[1]  = 4'b0001;
      dir_vec[2]  = 4'b0010; dir_vec[3]  = 4'b0100; dir_vec[4]  = 4'b1000;
      dir_vec[5]  = 4'b0011; dir_vec[6]  = 4'b0111; dir_vec[7]  = 4'b1111;
      dir_vec[8]  = 4'b0101; dir_vec[9]  = 4'b1001;
      dir_vec[10] = 4'b1100; dir_vec[11] = 4'b1110; dir_vec[12] = 4'b1011;
      dir_vec[13] = 4'b0110; dir_vec[14] = 4'b1010;
      dir_vec[15] = 4'b0001; dir_vec[16] = 4'b0000; dir_vec[17] = 4'b0100;
      for (int i = 0; i < 18; i++) apply(dir_vec[i], 1'b0);

      // Assert reset mid-stream, then release it and confirm encoding resumes.
      apply(4'b1000, 1'b0);
      apply(4'b1000, 1'b1);
      apply(4'b0100, 1'b0);
      apply(4'b0010, 1'b0);

      // Apply all 16 combinations exhaustively.
      for (int i = 0; i < 16; i++) apply(i[3:0], 1'b0);

      // Random inputs with occasional resets.
      for (int i = 0; i < 300; i++)
         apply(4'($urandom_range(0, 15)), ($urandom_range(0, 7) == 0));

      // Drain the final registered expectation.
      d   = 4'b0000;
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      #1;
      n_cmp++;
      if (q_reg.size() != 0 || q_comb.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d reg / %0d comb entries left, required 0 / 0",
                  q_reg.size(), q_comb.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
